dvd_motion_ctrl: RTL and testbench
==================================

// Module: dvd_motion_ctrl
// PURPOSE
//  Frame-rate scheduler for the one-pixel DVD sprite. Owns the sprite tile position,
//  direction and colour index. Sequences one bounded move per N frames from a
//  single-cycle frame_tick (from the hvsync generator), with pause/step, runtime reload
//  and bounce/corner events. Runs on the pixel clock; replaces per-vsync edge logic.
// PARAMETERS
//  X_MAX    19  last legal tile column (tile = 32 px)
//  Y_MAX    14  last legal tile row
//  X_INIT   10  column after reset
//  Y_INIT   7   row after reset
// PORTS
//  clk          in   1  pixel clock
//  rst_n        in   1  async active-low reset
//  frame_tick   in   1  1-cycle pulse, once per frame (start of vblank)
//  speed        in   3  move every speed+1 frames; sampled when the prescaler wraps
//  pause        in   1  level; frame_tick is ignored while high
//  step         in   1  1-cycle pulse; forces one move while pause=1, ignored otherwise
//  cfg_load     in   1  1-cycle pulse; load cfg_* now
//  cfg_x        in   5  new column (clamped to X_MAX)
//  cfg_y        in   4  new row (clamped to Y_MAX)
//  cfg_dir      in   2  {dir_x, dir_y}; 1 = increasing
//  pos_x        out  5  sprite column
//  pos_y        out  4  sprite row
//  dir_x/dir_y  out  1  current directions
//  color_idx    out  3  colour index, advanced on each bounce
//  bounce       out  1  1-cycle pulse: at least one axis reversed this move
//  corner       out  1  1-cycle pulse: both axes reversed in the same move
//  busy         out  1  high in S_CALC and S_COMMIT
// BEHAVIOUR
//  Reset: pos=(X_INIT,Y_INIT), dir=2'b11, color_idx=0, prescaler=0, state S_IDLE;
//   bounce, corner and busy are 0.
//  Trigger (S_IDLE only): frame_tick & ~pause & prescaler==speed, or step & pause.
//   frame_tick & ~pause & prescaler!=speed increments prescaler, no move.
//   Trigger from frame_tick clears prescaler; step leaves prescaler unchanged.
//  FSM: S_IDLE -trigger-> S_CALC -> S_COMMIT -> S_IDLE.
//   Edge E0 samples the trigger. E1 latches next pos/dir per axis.
//   E2 writes pos/dir/color_idx; bounce/corner are high E2..E3.
//  Per-axis move: dir=1 & pos==MAX  -> dir flips, pos holds, edge event.
//   dir=0 & pos==0 -> dir flips, pos holds, edge event. Otherwise pos +/- 1.
//   A position never leaves [0,MAX].
//  bounce = evx|evy; corner = evx&evy.
//   color_idx += 1 (mod 8, 7->0) once per move with bounce, including a corner move.
//  frame_tick/step while busy: dropped, prescaler unaffected (no queueing).
//  cfg_load in any state: aborts the in-flight move (no commit, no pulses).
//   Loads clamped pos and cfg_dir, clears prescaler, goes to S_IDLE; color_idx kept.
//   cfg_load wins over a coincident frame_tick/step.
//  Asynchronous rst_n mid-move: all state to reset values immediately.
// CONFIGURATION
//  DVD_CORNER_CNT_EN defined: adds output corner_cnt[7:0], reset 0.
//   Increments on each corner pulse, saturates at 255, cleared by cfg_load.
//  Undefined: the port and counter do not exist; all other behaviour is identical.
// STRUCTURE
//  Package dvd_pkg: state enum {S_IDLE,S_CALC,S_COMMIT}; default bounds/init
//   localparams; tile-size constant (5 = log2 32).
//  Sub-module dvd_axis_stepper (param W, MAX), instantiated for X and Y.
//   Combinational: pos, dir -> next_pos, next_dir, edge_ev.
// TESTING
//  1 Reset, speed=0, 3 frame_ticks -> pos_x 10->11->12->13, pos_y 7->8->9->10;
//    each update visible 2 edges after the tick; busy high exactly 2 cycles.
//  2 speed=2, 6 frame_ticks -> exactly 2 moves, on ticks 3 and 6.
//  3 cfg_load x=19,y=3,dir=2'b10, then 1 tick -> pos_x holds 19, dir_x=0,
//    bounce pulse, color_idx 0->1; next tick -> pos_x=18.
//  4 cfg_load x=0,y=0,dir=2'b00, tick -> corner and bounce high 1 cycle,
//    dirs=11, pos held; corner_cnt=1 if DVD_CORNER_CNT_EN.
//  5 pause=1: 5 ticks -> no change; step -> one move; step with pause=0 -> ignored.
//  6 cfg_load x=31,y=15 while in S_CALC -> pos=(19,14), no bounce pulse,
//    state S_IDLE; rst_n low in S_COMMIT -> pos=(10,7), color_idx=0.

Source files
------------

// File: rtl/dvd_pkg.sv
// Shared types and defaults for the DVD sprite motion controller.
// Optional build macro DVD_CORNER_CNT_EN is handled in dvd_motion_ctrl.
package dvd_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_COMMIT
    } state_e;

    localparam int X_MAX_DEF  = 19;
    localparam int Y_MAX_DEF  = 14;
    localparam int X_INIT_DEF = 10;
    localparam int Y_INIT_DEF = 7;

    localparam int X_W       = 5;
    localparam int Y_W       = 4;
    localparam int SPEED_W   = 3;
    localparam int COLOR_W   = 3;
    localparam int TILE_LOG2 = 5;  // 32-pixel tiles

endpackage

// File: rtl/dvd_axis_stepper.sv
// One-axis bounded stepper: moves one tile toward dir, or reverses at a wall.
module dvd_axis_stepper #(
    parameter int W   = 5,
    parameter int MAX = 19
) (
    input  logic [W-1:0] pos,
    input  logic         dir,
    output logic [W-1:0] next_pos,
    output logic         next_dir,
    output logic         edge_ev
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        next_pos = pos;
        next_dir = dir;
        edge_ev  = 1'b0;
        if (dir && pos >= W'(MAX)) begin
            next_dir = 1'b0;
            edge_ev  = 1'b1;
        end else if (!dir && pos == '0) begin
            next_dir = 1'b1;
            edge_ev  = 1'b1;
        end else if (dir) begin
            next_pos = pos + 1'b1;
        end else begin
            next_pos = pos - 1'b1;
        end
    end

endmodule

// File: rtl/dvd_motion_ctrl.sv
// Frame-rate scheduler for the DVD sprite: position, direction, colour, bounce events.
// Define DVD_CORNER_CNT_EN to add the saturating corner_cnt output.
module dvd_motion_ctrl
    import dvd_pkg::*;
#(
    parameter int X_MAX  = X_MAX_DEF,
    parameter int Y_MAX  = Y_MAX_DEF,
    parameter int X_INIT = X_INIT_DEF,
    parameter int Y_INIT = Y_INIT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic [SPEED_W-1:0] speed,
    input  logic               pause,
    input  logic               step,
    input  logic               cfg_load,
    input  logic [X_W-1:0]     cfg_x,
    input  logic [Y_W-1:0]     cfg_y,
    input  logic [1:0]         cfg_dir,
    output logic [X_W-1:0]     pos_x,
    output logic [Y_W-1:0]     pos_y,
    output logic               dir_x,
    output logic               dir_y,
    output logic [COLOR_W-1:0] color_idx,
    output logic               bounce,
    output logic               corner,
    output logic               busy
`ifdef DVD_CORNER_CNT_EN
    ,
    output logic [7:0]         corner_cnt
`endif
);

    state_e               state, state_nx;
    logic [SPEED_W-1:0]   prescaler;
    logic                 trigger;
    logic [X_W-1:0]       x_nx_c, x_nx_q, cfg_x_cl;
    logic [Y_W-1:0]       y_nx_c, y_nx_q, cfg_y_cl;
    logic                 dx_nx_c, dy_nx_c, dx_nx_q, dy_nx_q;
    logic                 evx_c, evy_c, evx_q, evy_q;

    assign trigger  = (frame_tick && !pause && prescaler == speed) || (step && pause);
    assign cfg_x_cl = (cfg_x > X_W'(X_MAX)) ? X_W'(X_MAX) : cfg_x;
    assign cfg_y_cl = (cfg_y > Y_W'(Y_MAX)) ? Y_W'(Y_MAX) : cfg_y;

    dvd_axis_stepper #(.W(X_W), .MAX(X_MAX)) u_step_x (
        .pos(pos_x), .dir(dir_x), .next_pos(x_nx_c), .next_dir(dx_nx_c), .edge_ev(evx_c)
    );

    dvd_axis_stepper #(.W(Y_W), .MAX(Y_MAX)) u_step_y (
        .pos(pos_y), .dir(dir_y), .next_pos(y_nx_c), .next_dir(dy_nx_c), .edge_ev(evy_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (cfg_load) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (trigger) state_nx = S_CALC;
                S_CALC:   state_nx = S_COMMIT;
                S_COMMIT: state_nx = S_IDLE;
                default:  state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x     <= X_W'(X_INIT);
            pos_y     <= Y_W'(Y_INIT);
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            color_idx <= '0;
            prescaler <= '0;
            bounce    <= 1'b0;
            corner    <= 1'b0;
            x_nx_q    <= '0;
            y_nx_q    <= '0;
            dx_nx_q   <= 1'b0;
            dy_nx_q   <= 1'b0;
            evx_q     <= 1'b0;
            evy_q     <= 1'b0;
        end else begin
            bounce <= 1'b0;
            corner <= 1'b0;
            if (cfg_load) begin
                // An in-flight move is simply dropped; colour survives a reload.
                pos_x     <= cfg_x_cl;
                pos_y     <= cfg_y_cl;
                dir_x     <= cfg_dir[1];
                dir_y     <= cfg_dir[0];
                prescaler <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (frame_tick && !pause)
                            prescaler <= (prescaler == speed) ? '0 : prescaler + 1'b1;
                    end
                    S_CALC: begin
                        x_nx_q  <= x_nx_c;
                        y_nx_q  <= y_nx_c;
                        dx_nx_q <= dx_nx_c;
                        dy_nx_q <= dy_nx_c;
                        evx_q   <= evx_c;
                        evy_q   <= evy_c;
                    end
                    S_COMMIT: begin
                        pos_x     <= x_nx_q;
                        pos_y     <= y_nx_q;
                        dir_x     <= dx_nx_q;
                        dir_y     <= dy_nx_q;
                        color_idx <= color_idx + COLOR_W'(evx_q | evy_q);
                        bounce    <= evx_q | evy_q;
                        corner    <= evx_q & evy_q;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef DVD_CORNER_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            corner_cnt <= '0;
        else if (cfg_load)
            corner_cnt <= '0;
        else if (state == S_COMMIT && evx_q && evy_q && corner_cnt != 8'hFF)
            corner_cnt <= corner_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_dvd_motion_ctrl.sv
// Self-checking bench for dvd_motion_ctrl: a move-level reference model compared every
// cycle, plus directed literal checks. Honours DVD_CORNER_CNT_EN when defined.
module tb_dvd_motion_ctrl;

    localparam int XM = 19;
    localparam int YM = 14;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick, pause, step, cfg_load;
    logic [2:0] speed;
    logic [4:0] cfg_x;
    logic [3:0] cfg_y;
    logic [1:0] cfg_dir;
    logic [4:0] pos_x;
    logic [3:0] pos_y;
    logic       dir_x, dir_y, bounce, corner, busy;
    logic [2:0] color_idx;
`ifdef DVD_CORNER_CNT_EN
    logic [7:0] corner_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dvd_motion_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .speed(speed), .pause(pause),
        .step(step), .cfg_load(cfg_load), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_dir(cfg_dir),
        .pos_x(pos_x), .pos_y(pos_y), .dir_x(dir_x), .dir_y(dir_y), .color_idx(color_idx),
        .bounce(bounce), .corner(corner), .busy(busy)
`ifdef DVD_CORNER_CNT_EN
        , .corner_cnt(corner_cnt)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: a move is pending for two cycles after being accepted, then
    // applied with plain signed arithmetic against the walls.
    int m_x, m_y, m_dx, m_dy, m_col, m_frames, m_wait, m_ccnt;
    int m_bounce, m_corner;

    function automatic void move_axis(inout int p, inout int d, input int max, output int ev);
        int t;
        t = p + (d != 0 ? 1 : -1);
        if (t < 0 || t > max) begin
            d  = (d != 0) ? 0 : 1;
            ev = 1;
        end else begin
            p  = t;
            ev = 0;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int ex, ey;
        if (!rst_n) begin
            m_x = 10; m_y = 7; m_dx = 1; m_dy = 1; m_col = 0;
            m_frames = 0; m_wait = 0; m_ccnt = 0; m_bounce = 0; m_corner = 0;
        end else begin
            m_bounce = 0;
            m_corner = 0;
            if (cfg_load) begin
                m_x = (cfg_x > XM) ? XM : int'(cfg_x);
                m_y = (cfg_y > YM) ? YM : int'(cfg_y);
                m_dx = cfg_dir[1];
                m_dy = cfg_dir[0];
                m_frames = 0; m_wait = 0; m_ccnt = 0;
            end else if (m_wait == 2) begin
                m_wait = 0;
                move_axis(m_x, m_dx, XM, ex);
                move_axis(m_y, m_dy, YM, ey);
                m_bounce = (ex != 0 || ey != 0) ? 1 : 0;
                m_corner = (ex != 0 && ey != 0) ? 1 : 0;
                m_col = (m_col + m_bounce) % 8;
                if (m_corner != 0 && m_ccnt < 255) m_ccnt++;
            end else if (m_wait == 1) begin
                m_wait = 2;
            end else if (pause && step) begin
                m_wait = 1;
            end else if (!pause && frame_tick) begin
                if (m_frames == int'(speed)) begin
                    m_frames = 0;
                    m_wait = 1;
                end else begin
                    m_frames = (m_frames + 1) % 8;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("cmp_pos_x", pos_x, m_x);
        check("cmp_pos_y", pos_y, m_y);
        check("cmp_dir_x", dir_x, m_dx);
        check("cmp_dir_y", dir_y, m_dy);
        check("cmp_color", color_idx, m_col);
        check("cmp_bounce", bounce, m_bounce);
        check("cmp_corner", corner, m_corner);
        check("cmp_busy", busy, (m_wait != 0) ? 1 : 0);
`ifdef DVD_CORNER_CNT_EN
        check("cmp_corner_cnt", corner_cnt, m_ccnt);
`endif
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    task automatic pulse_step();
        @(negedge clk) step = 1'b1;
        @(negedge clk) step = 1'b0;
    endtask

    task automatic load(input int x, input int y, input int d);
        @(negedge clk);
        cfg_load = 1'b1;
        cfg_x = 5'(x);
        cfg_y = 4'(y);
        cfg_dir = 2'(d);
        @(negedge clk) cfg_load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        frame_tick = 1'b0; pause = 1'b0; step = 1'b0; cfg_load = 1'b0;
        speed = 3'd0; cfg_x = '0; cfg_y = '0; cfg_dir = '0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(1);

        // Reset state
        check("rst_pos_x", pos_x, 10);
        check("rst_pos_y", pos_y, 7);
        check("rst_dirs", {dir_x, dir_y}, 3);
        check("rst_color", color_idx, 0);
        check("rst_busy", busy, 0);

        // Test 1: speed 0, three ticks; busy for exactly two cycles
        pulse_tick();
        check("t1_busy_calc", busy, 1);
        check("t1_pos_pre", pos_x, 10);
        wait_cyc(1);
        check("t1_busy_commit", busy, 1);
        wait_cyc(1);
        check("t1_busy_done", busy, 0);
        check("t1_pos_x1", pos_x, 11);
        check("t1_pos_y1", pos_y, 8);
        pulse_tick(); wait_cyc(3);
        pulse_tick(); wait_cyc(3);
        check("t1_pos_x3", pos_x, 13);
        check("t1_pos_y3", pos_y, 10);

        // Test 2: speed 2, six ticks -> moves on ticks 3 and 6
        speed = 3'd2;
        pulse_tick(); wait_cyc(3);
        pulse_tick(); wait_cyc(3);
        check("t2_no_move", pos_x, 13);
        pulse_tick(); wait_cyc(3);
        check("t2_move1", pos_x, 14);
        pulse_tick(); wait_cyc(3);
        pulse_tick(); wait_cyc(3);
        pulse_tick(); wait_cyc(3);
        check("t2_move2_x", pos_x, 15);
        check("t2_move2_y", pos_y, 12);
        speed = 3'd0;

        // Test 3: right-wall bounce
        load(19, 3, 2'b10);
        pulse_tick();
        wait_cyc(2);
        check("t3_bounce", bounce, 1);
        check("t3_corner", corner, 0);
        check("t3_pos_x", pos_x, 19);
        check("t3_dir_x", dir_x, 0);
        check("t3_pos_y", pos_y, 2);
        check("t3_color", color_idx, 1);
        wait_cyc(1);
        check("t3_bounce_end", bounce, 0);
        pulse_tick(); wait_cyc(3);
        check("t3_pos_x_next", pos_x, 18);

        // Test 4: corner at origin
        load(0, 0, 2'b00);
        pulse_tick();
        wait_cyc(2);
        check("t4_corner", corner, 1);
        check("t4_bounce", bounce, 1);
        check("t4_dirs", {dir_x, dir_y}, 3);
        check("t4_pos", {pos_x, pos_y}, 0);
        check("t4_color", color_idx, 2);
`ifdef DVD_CORNER_CNT_EN
        check("t4_corner_cnt", corner_cnt, 1);
`endif
        wait_cyc(1);
        check("t4_corner_end", corner, 0);

        // Test 5: pause/step
        pause = 1'b1;
        repeat (5) begin
            pulse_tick(); wait_cyc(2);
        end
        check("t5_paused_x", pos_x, 0);
        check("t5_paused_busy", busy, 0);
        pulse_step(); wait_cyc(3);
        check("t5_step_x", pos_x, 1);
        check("t5_step_y", pos_y, 1);
        pause = 1'b0;
        pulse_step(); wait_cyc(3);
        check("t5_step_ignored", pos_x, 1);

        // cfg_load coincident with a tick wins
        @(negedge clk);
        frame_tick = 1'b1; cfg_load = 1'b1; cfg_x = 5'd5; cfg_y = 4'd6; cfg_dir = 2'b01;
        @(negedge clk);
        frame_tick = 1'b0; cfg_load = 1'b0;
        check("t5_load_wins_busy", busy, 0);
        wait_cyc(3);
        check("t5_load_wins_x", pos_x, 5);

        // Test 6: abort in S_CALC, then async reset in S_COMMIT
        pulse_tick();
        cfg_load = 1'b1; cfg_x = 5'd31; cfg_y = 4'd15; cfg_dir = 2'b11;
        @(negedge clk) cfg_load = 1'b0;
        check("t6_abort_busy", busy, 0);
        wait_cyc(3);
        check("t6_clamp_x", pos_x, 19);
        check("t6_clamp_y", pos_y, 14);
        check("t6_no_bounce", bounce, 0);
        check("t6_color_kept", color_idx, 2);
        pulse_tick();
        wait_cyc(1);
        check("t6_in_commit", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_x", pos_x, 10);
        check("t6_rst_y", pos_y, 7);
        check("t6_rst_color", color_idx, 0);
        check("t6_rst_busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;
        pulse_tick(); wait_cyc(3);
        check("t6_after_rst_x", pos_x, 11);
        check("t6_after_rst_y", pos_y, 8);

        wait_cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
